// File: rtl/command_input_decoder_if.sv
// Button/count/command bundle for command_input_decoder.
// The cmd_pulse signal exists only when CMD_PULSE_EN is defined.
interface command_input_decoder_if #(
    parameter int N_BTN  = 4,
    parameter int DIGITS = 4
);
    logic [N_BTN-1:0]    btn;
    logic [4*DIGITS-1:0] digits;
    logic [N_BTN-1:0]    cmd;
    logic                armed;
`ifdef CMD_PULSE_EN
    logic [N_BTN-1:0]    cmd_pulse;

    modport master (output btn, digits, input cmd, armed, cmd_pulse);
    modport slave  (input btn, digits, output cmd, armed, cmd_pulse);
`else
    modport master (output btn, digits, input cmd, armed);
    modport slave  (input btn, digits, output cmd, armed);
`endif
endinterface

// File: rtl/command_input_decoder.sv
// Synchronised, debounced N-button command receiver with a held one-hot command and BCD limit reset.
// Optional feature macro: CMD_PULSE_EN adds a one-cycle cmd_pulse strobe per written command.
module command_input_decoder #(
    parameter int N_BTN          = 4,
    parameter int DEB_CYCLES     = 16,
    parameter int DIGITS         = 4,
    parameter int RESET_IDX      = 0,
    parameter int BTN_ACTIVE_LOW = 1
) (
    input  logic                    clock,
    input  logic                    reset,
    command_input_decoder_if.slave  bus
);
    localparam int IW = (N_BTN > 2) ? $clog2(N_BTN) : 1;
    localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [N_BTN-1:0] RELEASED_RAW = (BTN_ACTIVE_LOW != 0) ? '1 : '0;
    localparam logic [N_BTN-1:0] RESET_CMD    = N_BTN'(1) << RESET_IDX;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ARMED   = 2'd1;
    localparam logic [1:0] S_LOCKOUT = 2'd2;

    logic [N_BTN-1:0] sync1, sync2, pressed_sync, deb;
    logic [CW-1:0]    cnt [N_BTN];
    logic [1:0]       state, state_nxt;
    logic [IW-1:0]    idx, p_idx;
    logic [N_BTN-1:0] cmd_q, idx_sel;
    logic             armed_q, one_hot_p, limit, limit_q, release_issue;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1 <= RELEASED_RAW;
            sync2 <= RELEASED_RAW;
        end else begin
            sync1 <= bus.btn;
            sync2 <= sync1;
        end
    end

    assign pressed_sync = (BTN_ACTIVE_LOW != 0) ? ~sync2 : sync2;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            deb <= '0;
            for (int unsigned i = 0; i < N_BTN; i++) cnt[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < N_BTN; i++) begin
                if (pressed_sync[i] == deb[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CW'(DEB_CYCLES - 1)) begin
                    deb[i] <= pressed_sync[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    assign one_hot_p = (deb != '0) && ((deb & (deb - 1'b1)) == '0);
    assign idx_sel   = N_BTN'(1) << idx;

    always_comb begin
        p_idx = '0;
        for (int unsigned i = 0; i < N_BTN; i++) if (deb[i]) p_idx = IW'(i);
    end

    // Non-BCD nibbles simply fail the equality, so they can never trigger the limit.
    always_comb begin
        limit = 1'b1;
        for (int unsigned k = 0; k < DIGITS; k++)
            if (bus.digits[4*k +: 4] != 4'd9) limit = 1'b0;
    end

    always_comb begin
        state_nxt     = state;
        release_issue = 1'b0;
        case (state)
            S_IDLE: begin
                if (one_hot_p)       state_nxt = S_ARMED;
                else if (deb != '0)  state_nxt = S_LOCKOUT;
            end
            S_ARMED: begin
                if (limit) begin
                    state_nxt = S_LOCKOUT;
                end else if (deb == '0) begin
                    state_nxt     = S_IDLE;
                    release_issue = 1'b1;
                end else if ((deb & ~idx_sel) != '0) begin
                    state_nxt = S_LOCKOUT;
                end
            end
            S_LOCKOUT: if (deb == '0) state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            idx     <= '0;
            cmd_q   <= RESET_CMD;
            armed_q <= 1'b0;
            limit_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            armed_q <= (state_nxt == S_ARMED);
            limit_q <= limit;
            if (state == S_IDLE && one_hot_p) idx <= p_idx;
            if (limit)              cmd_q <= RESET_CMD;
            else if (release_issue) cmd_q <= idx_sel;
        end
    end

    assign bus.cmd   = cmd_q;
    assign bus.armed = armed_q;

`ifdef CMD_PULSE_EN
    logic [N_BTN-1:0] pulse_q;

    // Limit pulses only on entry; a held limit keeps rewriting cmd silently.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pulse_q <= '0;
        end else if (limit) begin
            pulse_q <= limit_q ? '0 : RESET_CMD;
        end else if (release_issue) begin
            pulse_q <= idx_sel;
        end else begin
            pulse_q <= '0;
        end
    end

    assign bus.cmd_pulse = pulse_q;
`endif
endmodule
